// File: rtl/fir_bcd_display_if.sv
// Bus between the FIR output stage and its consumer.
//   load/din : capture strobe and 16-bit value to convert (consumer -> stage)
//   busy     : conversion in progress
//   valid    : one-cycle pulse, bcd/ovf just updated
//   bcd/ovf  : five BCD digits and ten-thousands-nonzero flag
//   an/seg   : active-low digit enables and gfedcba segments
interface fir_bcd_display_if;
  logic        load;
  logic [15:0] din;
  logic        busy;
  logic        valid;
  logic [19:0] bcd;
  logic        ovf;
  logic [3:0]  an;
  logic [6:0]  seg;

  modport master (
    output load, din,
    input  busy, valid, bcd, ovf, an, seg
  );

  modport slave (
    input  load, din,
    output busy, valid, bcd, ovf, an, seg
  );
endinterface

// File: rtl/fir_bcd_display.sv
// FIR output stage: captures a 16-bit value, converts it to five BCD digits
// with a 16-cycle shift-and-add-3 engine and scans the low four digits onto
// a common-anode seven-segment display.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : fir_bcd_display_if.slave (load/din in; busy/valid/bcd/ovf/an/seg out)
module fir_bcd_display #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter bit          LZB         = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  fir_bcd_display_if.slave  bus
);

  localparam int unsigned DW = 16;
  localparam int unsigned BW = 20;
  localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t          state;
  logic [DW-1:0]   sr;
  logic [BW-1:0]   acc;
  logic [3:0]      i;
  logic [BW-1:0]   acc_adj_c;
  logic [BW+DW-1:0] shifted_c;

  // Add-3 correction on every nibble >= 5, then one left shift of {acc,sr}.
  always_comb begin
    acc_adj_c = acc;
    for (int n = 0; n < 5; n++) begin
      if (acc[n*4 +: 4] >= 4'd5) acc_adj_c[n*4 +: 4] = acc[n*4 +: 4] + 4'd3;
    end
    shifted_c = {acc_adj_c, sr} << 1;
  end

  // Conversion FSM; bcd/ovf are only written on the final iteration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sr        <= '0;
      acc       <= '0;
      i         <= '0;
      bus.busy  <= 1'b0;
      bus.valid <= 1'b0;
      bus.bcd   <= '0;
      bus.ovf   <= 1'b0;
    end else begin
      bus.valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.load) begin
            sr       <= bus.din;
            acc      <= '0;
            i        <= '0;
            bus.busy <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          acc <= shifted_c[BW+DW-1:DW];
          sr  <= shifted_c[DW-1:0];
          i   <= i + 4'd1;
          if (i == 4'd15) begin
            bus.bcd   <= shifted_c[BW+DW-1:DW];
            bus.ovf   <= |shifted_c[BW+DW-1:BW+DW-4];
            bus.valid <= 1'b1;
            bus.busy  <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b1111111;
    endcase
  endfunction

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [3:0]    nib_c;
  logic          zero_above_c;
  logic          blank_c;

  // Select the scanned nibble; a digit is a leading zero when it and every
  // displayed digit above it are zero.
  always_comb begin
    nib_c        = bus.bcd[3:0];
    zero_above_c = 1'b0;
    case (idx)
      2'd0: nib_c = bus.bcd[3:0];
      2'd1: begin
        nib_c        = bus.bcd[7:4];
        zero_above_c = (bus.bcd[15:4] == 12'd0);
      end
      2'd2: begin
        nib_c        = bus.bcd[11:8];
        zero_above_c = (bus.bcd[15:8] == 8'd0);
      end
      default: begin
        nib_c        = bus.bcd[15:12];
        zero_above_c = (bus.bcd[15:12] == 4'd0);
      end
    endcase
    blank_c = LZB && !bus.ovf && zero_above_c;
  end

  // Free-running digit scan, independent of the conversion FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      idx     <= '0;
      bus.an  <= 4'b1110;
      bus.seg <= 7'b1000000;
    end else begin
      if (cnt == CW'(REFRESH_DIV - 1)) begin
        cnt <= '0;
        idx <= idx + 2'd1;
      end else begin
        cnt <= cnt + CW'(1);
      end
      bus.an  <= ~(4'b0001 << idx);
      bus.seg <= blank_c ? 7'b1111111 : decode(nib_c);
    end
  end

endmodule

// File: tb/tb_fir_bcd_display.sv
// Self-checking bench for fir_bcd_display with a fast refresh divider.
module tb_fir_bcd_display;
  localparam int unsigned RDIV = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fir_bcd_display_if bus();

  fir_bcd_display #(.REFRESH_DIV(RDIV), .LZB(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: decimal digits by plain division.
  function automatic logic [19:0] ref_bcd(input int unsigned v);
    logic [19:0] r;
    int unsigned p;
    r = '0;
    p = 1;
    for (int d = 0; d < 5; d++) begin
      r[d*4 +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [6:0] ref_glyph(input int unsigned d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Displayed pattern of digit k for value v, leading-zero blanking enabled.
  function automatic logic [6:0] ref_seg(input int unsigned v, input int k);
    int unsigned pw;
    pw = 1;
    for (int j = 0; j < k; j++) pw = pw * 10;
    if (k > 0 && v < 10000 && (v % 10000) < pw) return 7'b1111111;
    return ref_glyph((v / pw) % 10);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait until digit k is enabled (bounded) and return its segments.
  task automatic show_digit(input int k, output logic [6:0] s, output bit ok);
    logic [3:0] want;
    want = ~4'(1 << k);
    ok = 1'b0;
    for (int c = 0; c < 4 * RDIV + 4; c++) begin
      tick();
      if (bus.an === want) begin
        ok = 1'b1;
        break;
      end
    end
    s = bus.seg;
  endtask

  // Issue one load and observe the result; no checking here.
  task automatic run_load(input logic [15:0] v, output int lat, output logic [19:0] b,
                          output logic o, output logic busy_after);
    bus.din  = v;
    bus.load = 1'b1;
    tick();
    bus.load   = 1'b0;
    busy_after = bus.busy;
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (bus.valid === 1'b1) begin
        lat = c;
        break;
      end
    end
    b = bus.bcd;
    o = bus.ovf;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.load = 1'b0;
    bus.din  = '0;
    tick();
    tick();
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_tests++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus.valid); end
    n_tests++; if (bus.bcd !== 20'h0) begin n_fail++; $display("FAIL reset_bcd got %h want 00000", bus.bcd); end
    n_tests++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", bus.ovf); end
    n_tests++; if (bus.an !== 4'b1110) begin n_fail++; $display("FAIL reset_an got %b want 1110", bus.an); end
    n_tests++; if (bus.seg !== 7'b1000000) begin n_fail++; $display("FAIL reset_seg got %b want 1000000", bus.seg); end
    rst = 1'b0;
    tick();
  endtask

  // Convert v, check result/latency/pulse width, then all four displayed digits.
  task automatic test_value(input int unsigned v, input string name);
    int lat; logic [19:0] b; logic o, ba; logic [6:0] s; bit ok;
    run_load(16'(v), lat, b, o, ba);
    n_tests++; if (ba !== 1'b1) begin n_fail++; $display("FAIL %s_busy got %b want 1", name, ba); end
    n_tests++; if (lat != 16) begin n_fail++; $display("FAIL %s_latency got %0d want 16", name, lat); end
    n_tests++; if (b !== ref_bcd(v)) begin n_fail++; $display("FAIL %s_bcd got %h want %h", name, b, ref_bcd(v)); end
    n_tests++; if (o !== (v > 9999)) begin n_fail++; $display("FAIL %s_ovf got %b want %b", name, o, (v > 9999)); end
    tick();
    n_tests++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL %s_valid_drop got %b want 0", name, bus.valid); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL %s_busy_drop got %b want 0", name, bus.busy); end
    for (int k = 3; k >= 0; k--) begin
      show_digit(k, s, ok);
      n_tests++;
      if (!ok || s !== ref_seg(v, k)) begin
        n_fail++;
        $display("FAIL %s_digit%0d found=%0d got %b want %b", name, k, ok, s, ref_seg(v, k));
      end
    end
  endtask

  // Loads during SHIFT (mid-conversion and at the completing edge) are dropped.
  task automatic test_load_ignored();
    int first_valid; int lat; logic [19:0] b; logic o, ba;
    first_valid = 0;
    bus.din  = 16'd9999;
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      if (c == 5 || c == 16) begin
        bus.din  = 16'd65535;
        bus.load = 1'b1;
      end
      tick();
      bus.load = 1'b0;
      if (bus.valid === 1'b1 && first_valid == 0) first_valid = c;
    end
    n_tests++; if (first_valid != 16) begin n_fail++; $display("FAIL ignore_latency got %0d want 16", first_valid); end
    n_tests++; if (bus.bcd !== ref_bcd(9999)) begin n_fail++; $display("FAIL ignore_bcd got %h want %h", bus.bcd, ref_bcd(9999)); end
    n_tests++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL ignore_ovf got %b want 0", bus.ovf); end
    tick();
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL ignore_coincident_busy got %b want 0", bus.busy); end
    tick();
    n_tests++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL ignore_extra_valid got %b want 0", bus.valid); end
    run_load(16'd65535, lat, b, o, ba);
    n_tests++; if (lat != 16) begin n_fail++; $display("FAIL reload_latency got %0d want 16", lat); end
    n_tests++; if (b !== 20'h65535) begin n_fail++; $display("FAIL reload_bcd got %h want 65535", b); end
    n_tests++; if (o !== 1'b1) begin n_fail++; $display("FAIL reload_ovf got %b want 1", o); end
    tick();
  endtask

  task automatic test_rst_abort();
    int vcount; int lat; logic [19:0] b; logic o, ba;
    bus.din  = 16'd500;
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    for (int c = 0; c < 8; c++) tick();
    rst = 1'b1;
    #1;
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b want 0", bus.busy); end
    n_tests++; if (bus.bcd !== 20'h0) begin n_fail++; $display("FAIL abort_bcd got %h want 00000", bus.bcd); end
    n_tests++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL abort_valid got %b want 0", bus.valid); end
    tick();
    rst = 1'b0;
    vcount = 0;
    for (int c = 0; c < 24; c++) begin
      tick();
      if (bus.valid === 1'b1) vcount++;
    end
    n_tests++; if (vcount != 0) begin n_fail++; $display("FAIL abort_no_valid got %0d pulses want 0", vcount); end
    run_load(16'd500, lat, b, o, ba);
    n_tests++; if (b !== 20'h00500 || lat != 16) begin n_fail++; $display("FAIL abort_reload got %h lat %0d want 00500 lat 16", b, lat); end
    tick();
  endtask

  // Scan order 1110,1101,1011,0111,... each held RDIV cycles after reset.
  task automatic test_refresh();
    logic [3:0] s [24];
    int j0;
    logic [3:0] want;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int j = 0; j < 24; j++) begin
      tick();
      s[j] = bus.an;
    end
    n_tests++; if (s[0] !== 4'b1110) begin n_fail++; $display("FAIL scan_start got %b want 1110", s[0]); end
    j0 = 0;
    for (int j = 1; j < 24; j++) begin
      if (s[j] !== s[0]) begin j0 = j; break; end
    end
    n_tests++;
    if (j0 < 1 || j0 > int'(RDIV)) begin
      n_fail++;
      $display("FAIL scan_first_change got %0d want 1..%0d", j0, RDIV);
    end else begin
      for (int j = j0; j < 24; j++) begin
        want = ~4'(1 << ((1 + (j - j0) / int'(RDIV)) % 4));
        n_tests++;
        if (s[j] !== want) begin n_fail++; $display("FAIL scan_an[%0d] got %b want %b", j, s[j], want); end
      end
    end
  endtask

  task automatic test_random();
    int lat; logic [19:0] b; logic o, ba; int unsigned v;
    for (int t = 0; t < 200; t++) begin
      v = $urandom_range(0, 65535);
      run_load(16'(v), lat, b, o, ba);
      n_tests++; if (lat != 16) begin n_fail++; $display("FAIL rand_latency v=%0d got %0d want 16", v, lat); end
      n_tests++; if (b !== ref_bcd(v) || o !== (v > 9999)) begin
        n_fail++; $display("FAIL rand_bcd v=%0d got %h/%b want %h/%b", v, b, o, ref_bcd(v), (v > 9999));
      end
      tick();
      n_tests++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL rand_single_valid v=%0d got %b want 0", v, bus.valid); end
    end
  endtask

  initial begin
    test_reset();
    test_value(11475, "v11475");
    test_value(42, "v42");
    test_load_ignored();
    test_rst_abort();
    test_refresh();
    test_value(0, "v0");
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got stuck want completion");
    $fatal(1, "timeout");
  end

endmodule
